// File: rtl/fifo_reg_sync.sv
// fifo_reg_sync: single-clock register FIFO with fill level, programmable thresholds and sticky errors.
// Define FIFO_REG_SYNC_FWFT_EN for first-word-fall-through reads; default is registered read.
module fifo_reg_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 16,
    localparam int LVL_W = $clog2(DATA_DEPTH + 1),
    localparam int AW = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_dv,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic [LVL_W-1:0]      af_thr,
    input  logic [LVL_W-1:0]      ae_thr,
    output logic [LVL_W-1:0]      level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic overflow_q, overflow_d, underflow_q, underflow_d;
    logic rd_acc, wr_acc;

    assign full = level_q == LVL_W'(DATA_DEPTH);
    assign empty = level_q == '0;
    assign almost_full = level_q >= af_thr;
    assign almost_empty = level_q <= ae_thr;
    assign level = level_q;
    assign overflow = overflow_q;
    assign underflow = underflow_q;
    // A read on a full FIFO frees the slot the simultaneous write lands in.
    assign rd_acc = rd_en & !empty;
    assign wr_acc = wr_dv & (!full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_acc ? ((wr_ptr_q == AW'(DATA_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? ((rd_ptr_q == AW'(DATA_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        level_d = (wr_acc && !rd_acc) ? level_q + 1'b1 :
                  (rd_acc && !wr_acc) ? level_q - 1'b1 : level_q;
        overflow_d = (wr_dv & !wr_acc) | (overflow_q & !err_clr);
        underflow_d = (rd_en & empty) | (underflow_q & !err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q <= '0;
            overflow_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q <= level_d;
            overflow_q <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= wr_data;
    end

`ifdef FIFO_REG_SYNC_FWFT_EN
    assign rd_data = empty ? '0 : mem[rd_ptr_q];
    assign rd_valid = !empty;
`else
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic rd_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign rd_data = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif
endmodule

// File: tb/tb_fifo_reg_sync.sv
// tb_fifo_reg_sync: drives a depth-16 and a depth-5 FIFO with identical traffic
// and checks both against a queue-based reference model every cycle.
module tb_fifo_reg_sync;
    logic clk = 0, rst = 0, wr_dv = 0, rd_en = 0, err_clr = 0;
    logic [7:0] wr_data = 0;
    logic [4:0] af0 = 5'd12, ae0 = 5'd2;
    logic [2:0] af1 = 3'd4, ae1 = 3'd1;
    logic [7:0] rdd [2];
    logic rdv [2], ful [2], emp [2], afl [2], ael [2], ovf [2], unf [2];
    logic [4:0] lvl0;
    logic [2:0] lvl1;
    logic [4:0] lvl [2];
    int checks = 0, errors = 0;
    int dep [2] = '{16, 5};
    int afv [2] = '{12, 4};
    int aev [2] = '{2, 1};
    int mlvl [2];
    bit mo [2], mu [2];
    logic [7:0] last [2];
    logic [7:0] q0 [$], q1 [$];

    assign lvl[0] = lvl0;
    assign lvl[1] = {2'b0, lvl1};

    always #5 clk = ~clk;

    fifo_reg_sync #(.DATA_WIDTH(8), .DATA_DEPTH(16)) u0 (
        .clk(clk), .rst(rst), .wr_dv(wr_dv), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rdd[0]), .rd_valid(rdv[0]), .full(ful[0]), .empty(emp[0]),
        .almost_full(afl[0]), .almost_empty(ael[0]), .af_thr(af0), .ae_thr(ae0),
        .level(lvl0), .overflow(ovf[0]), .underflow(unf[0]), .err_clr(err_clr)
    );

    fifo_reg_sync #(.DATA_WIDTH(8), .DATA_DEPTH(5)) u1 (
        .clk(clk), .rst(rst), .wr_dv(wr_dv), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rdd[1]), .rd_valid(rdv[1]), .full(ful[1]), .empty(emp[1]),
        .almost_full(afl[1]), .almost_empty(ael[1]), .af_thr(af1), .ae_thr(ae1),
        .level(lvl1), .overflow(ovf[1]), .underflow(unf[1]), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic chk_flags(input int d);
        chk("level", d, lvl[d], mlvl[d]);
        chk("full", d, ful[d], mlvl[d] == dep[d]);
        chk("empty", d, emp[d], mlvl[d] == 0);
        chk("almost_full", d, afl[d], mlvl[d] >= afv[d]);
        chk("almost_empty", d, ael[d], mlvl[d] <= aev[d]);
        chk("overflow", d, ovf[d], mo[d]);
        chk("underflow", d, unf[d], mu[d]);
    endtask

    task automatic step(input logic wv, input logic [7:0] wd, input logic re, input logic clr);
        bit racc [2];
        bit wacc;
        @(negedge clk);
        wr_dv = wv; wr_data = wd; rd_en = re; err_clr = clr;
        for (int d = 0; d < 2; d++) begin
            racc[d] = re && mlvl[d] > 0;
            wacc = wv && (mlvl[d] < dep[d] || racc[d]);
            mu[d] = (re && mlvl[d] == 0) || (mu[d] && !clr);
            mo[d] = (wv && !wacc) || (mo[d] && !clr);
            if (racc[d]) last[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
            if (wacc) begin
                if (d == 0) q0.push_back(wd);
                else q1.push_back(wd);
            end
            mlvl[d] += int'(wacc) - int'(racc[d]);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
`ifdef FIFO_REG_SYNC_FWFT_EN
            chk("rd_valid", d, rdv[d], mlvl[d] > 0);
            if (mlvl[d] > 0) chk("rd_data", d, rdd[d], (d == 0) ? q0[0] : q1[0]);
`else
            chk("rd_valid", d, rdv[d], racc[d]);
            chk("rd_data", d, rdd[d], last[d]);
`endif
            chk_flags(d);
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            mlvl[d] = 0; mo[d] = 0; mu[d] = 0; last[d] = 0;
        end
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
`ifndef FIFO_REG_SYNC_FWFT_EN
            chk("rst_rd_data", d, rdd[d], 0);
`endif
            chk("rst_rd_valid", d, rdv[d], 0);
            chk_flags(d);
        end
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        wr_dv = 0; rd_en = 0; err_clr = 0;
        @(negedge clk);
        do_reset();
        // fill: depth-16 reaches full on the 16th word, depth-5 overflows early
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
        step(1, 8'h10, 0, 0);
        // write and read together on a full FIFO
        step(1, 8'hAA, 1, 0);
        for (int i = 0; i < 17; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);
        // empty read, then set-beats-clear, then clear
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 1);
        step(0, 8'h00, 0, 1);
        // write and read together on an empty FIFO
        step(1, 8'h55, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);
        // interleaved traffic across pointer wrap
        for (int i = 0; i < 12; i++) begin
            step(1, 8'(8'h80 + i), 0, 0);
            step(1, 8'(8'hC0 + i), 1, 0);
        end
        for (int i = 0; i < 14; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);
        // async reset in the middle of a burst
        for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0, 0);
        @(negedge clk);
        wr_dv = 1; wr_data = 8'h3F;
        do_reset();
        wr_dv = 0;
        step(1, 8'h3C, 0, 0);
        step(0, 8'h00, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_reg_sync.md
Name: fifo_reg_sync

Overview:
Parametrised single-clock register FIFO, the next generation of the sniffer's packet/byte buffering FIFO. Adds concurrent read and write in the same cycle, a non-power-of-two depth, a fill-level output, runtime-programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. Sits between the ULPI receive path and the UART/USB transmit path of the USB3300 sniffer.

Parameters:
- DATA_WIDTH, 8, bits per word (>=1).
- DATA_DEPTH, 16, number of words (>=2; any integer, not restricted to powers of two).
- LVL_W, $clog2(DATA_DEPTH+1), width of level and threshold ports (localparam, derived).
- AW, $clog2(DATA_DEPTH), pointer width (localparam, derived).

Ports:
- clk  in  1  reference clock, all logic on posedge.
- rst  in  1  reset, asynchronous, active-low.
- wr_dv  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  read word.
- rd_valid  out  1  rd_data holds a newly popped word.
- full  out  1  level == DATA_DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= af_thr.
- almost_empty  out  1  level <= ae_thr.
- af_thr  in  LVL_W  almost-full threshold, sampled combinationally.
- ae_thr  in  LVL_W  almost-empty threshold, sampled combinationally.
- level  out  LVL_W  current number of stored words.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- err_clr  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rst low, async): wr_ptr=0, rd_ptr=0, level=0, rd_data=0, rd_valid=0, overflow=0, underflow=0; empty=1, full=0, almost_empty=1 (ae_thr>=0), almost_full=(af_thr==0). Storage array is not reset.
- rd_acc = rd_en & !empty. wr_acc = wr_dv & (!full | rd_acc). When full, a simultaneous read frees the slot and the write is accepted.
- Write: on wr_acc, mem[wr_ptr] <= wr_data; wr_ptr advances; wraps DATA_DEPTH-1 -> 0 (explicit compare, not modulo-2^AW).
- Read (standard mode): on rd_acc, rd_data <= mem[rd_ptr] and rd_ptr advances with the same wrap rule. Latency is 1 cycle: rd_valid=1 in the cycle after rd_acc, otherwise 0. rd_data holds its value when no read occurs.
- Level: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. Never exceeds DATA_DEPTH and never goes below 0.
- Simultaneous read and write while empty: the read is rejected (underflow set) and the write is accepted. The word becomes readable from the next cycle; there is no write-through.
- All flags are combinational from registered level and the threshold inputs.
- overflow <= 1 when wr_dv & !wr_acc. underflow <= 1 when rd_en & empty. Both hold until err_clr=1 or reset. If err_clr and a new error occur in the same cycle, set wins.
- Reset asserted mid-operation aborts immediately. Contents are lost and the FIFO is reported empty.

Optional Feature:
- Macro FIFO_REG_SYNC_FWFT_EN.
- Defined: first-word-fall-through mode. rd_data = mem[rd_ptr] combinationally whenever !empty. rd_valid = !empty. rd_en acknowledges (pops) the displayed word. Read latency is 0. Underflow and acceptance rules are unchanged.
- Undefined: standard registered-read mode as described under Behaviour.

Test Plan:
- Reset, then 16 writes of 0x00..0x0F -> level counts 1..16, full=1 after the 16th write; almost_full rises when level reaches af_thr=12; 17th write -> overflow=1, level stays 16.
- Full FIFO, wr_dv=1 with data 0xAA and rd_en=1 in the same cycle -> both accepted, level stays 16, next-cycle rd_data=0x00 with rd_valid=1, and 0xAA is read last.
- DATA_DEPTH=5, 12 interleaved write/read pairs -> data returned in order across pointer wrap 4->0, level never exceeds 5.
- Empty FIFO, rd_en=1 -> underflow=1, rd_valid=0, rd_data unchanged; err_clr=1 for one cycle -> underflow=0.
- Empty FIFO, wr_dv=1 (0x55) and rd_en=1 in the same cycle -> underflow=1, level=1; following read returns 0x55.
- FWFT build: single write of 0x3C -> rd_data=0x3C and rd_valid=1 one cycle later with no rd_en; pulse rd_en -> empty=1. Assert rst mid-burst -> level=0 and empty=1 immediately.
